// File: rtl/sand_pkg.sv
// Shared material codes, FSM state encoding and sizing constants for the sand engine.
package sand_pkg;

    localparam int unsigned CELL_WIDTH_MIN = 2;
    // Candidate slots: 0 below, 1/2 lower diagonals, 3/4 same-row sides
    localparam int unsigned NUM_CAND       = 5;
    localparam int unsigned SAND_CAND      = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SAND  = 2'd1,
        WATER = 2'd2,
        WALL  = 2'd3
    } material_e;

    typedef enum logic [3:0] {
        IDLE,
        BRUSH,
        RD_CELL,
        WAIT_CELL,
        RD_NBR,
        WAIT_NBR,
        WR_DST,
        WR_SRC,
        NEXT
    } state_e;

endpackage

// File: rtl/neighbour_addr_gen.sv
// Combinational candidate address and left/right edge validity for the current cell.
module neighbour_addr_gen
    import sand_pkg::*;
#(
    parameter int unsigned COLUMNS    = 640,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9
) (
    input  logic [XW-1:0]         x_i,
    input  logic [YW-1:0]         y_i,
    input  logic                  parity_i,
    input  logic [2:0]            idx_i,
    output logic [ADDR_WIDTH-1:0] addr_c_o,
    output logic                  side_right_c_o,
    output logic [NUM_CAND-1:0]   valid_c_o
);

    logic left_ok;
    logic right_ok;
    logic left_first;
    int   dx;
    int   dy;

    // Even parity looks left first, odd parity right first; below is always in-grid
    always_comb begin
        left_ok    = (x_i != '0);
        right_ok   = (int'(x_i) < int'(COLUMNS) - 1);
        left_first = ~parity_i;

        valid_c_o[0] = 1'b1;
        valid_c_o[1] = left_first ? left_ok  : right_ok;
        valid_c_o[2] = left_first ? right_ok : left_ok;
        valid_c_o[3] = left_first ? left_ok  : right_ok;
        valid_c_o[4] = left_first ? right_ok : left_ok;

        dy = (idx_i < 3'd3) ? 1 : 0;
        case (idx_i)
            3'd1, 3'd3: dx = left_first ? -1 : 1;
            3'd2, 3'd4: dx = left_first ? 1 : -1;
            default:    dx = 0;
        endcase

        addr_c_o       = ADDR_WIDTH'((int'(y_i) + dy) * int'(COLUMNS) + int'(x_i) + dx);
        side_right_c_o = (idx_i >= 3'd3) && (dx == 1);
    end

endmodule

// File: rtl/multi_material_update_engine.sv
// Falling-sand frame engine: bottom-up cell scan with sand/water movement and a square brush.
module multi_material_update_engine
    import sand_pkg::*;
#(
    parameter int unsigned COLUMNS      = 640,
    parameter int unsigned ROWS         = 480,
    parameter int unsigned CELL_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH   = $clog2(COLUMNS * ROWS),
    parameter int unsigned BRUSH_RADIUS = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic                       draw_req_i,
    input  logic [$clog2(COLUMNS)-1:0] draw_x_i,
    input  logic [$clog2(ROWS)-1:0]    draw_y_i,
    input  logic [CELL_WIDTH-1:0]      draw_material_i,
    output logic [ADDR_WIDTH-1:0]      rd_addr_o,
    input  logic [CELL_WIDTH-1:0]      rd_data_i,
    output logic                       wr_en_o,
    output logic [ADDR_WIDTH-1:0]      wr_addr_o,
    output logic [CELL_WIDTH-1:0]      wr_data_o,
    output logic                       busy_o,
    output logic                       draw_busy_o,
    output logic                       frame_done_o,
    output logic                       overrun_o
);

    localparam int unsigned XW    = $clog2(COLUMNS);
    localparam int unsigned YW    = $clog2(ROWS);
    localparam int unsigned BSIDE = 2 * BRUSH_RADIUS + 1;
    localparam int unsigned BW    = (BSIDE > 1) ? $clog2(BSIDE) : 1;

    state_e                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d, bcx_q, bcx_d;
    logic [YW-1:0]           y_q, y_d, bcy_q, bcy_d;
    logic [BW-1:0]           bx_q, bx_d, by_q, by_d;
    logic [CELL_WIDTH-1:0]   bmat_q, bmat_d;
    material_e               cell_q, cell_d;
    logic [2:0]              cand_q, cand_d;
    logic [ADDR_WIDTH-1:0]   tgt_addr_q, tgt_addr_d;
    logic                    side_right_q, side_right_d;
    logic                    skip_q, skip_d;
    logic                    parity_q, parity_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [CELL_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d, busy_q, busy_d, draw_busy_q, draw_busy_d;
    logic                    frame_done_q, frame_done_d, overrun_q, overrun_d;

    material_e               rd_mat_c, mat_sel_c;
    logic [2:0]              start_c, lim_c, nxt_idx_c;
    logic                    found_c, last_c, nbr_side_right_c;
    logic [NUM_CAND-1:0]     cand_valid_c;
    logic [ADDR_WIDTH-1:0]   nbr_addr_c;
    logic [XW-1:0]           nx_c, brush_cx_c;
    logic [YW-1:0]           ny_c, brush_cy_c;
    logic [CELL_WIDTH-1:0]   brush_mat_c;
    int                      xn, px, py;

    function automatic material_e decode(input logic [CELL_WIDTH-1:0] code);
        if (code > CELL_WIDTH'(3)) return WALL;
        return material_e'(code[1:0]);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return ADDR_WIDTH'(int'(y) * int'(COLUMNS) + int'(x));
    endfunction

    assign rd_mat_c    = decode(rd_data_i);
    assign mat_sel_c   = (state_q == WAIT_CELL) ? rd_mat_c : cell_q;
    assign start_c     = (state_q == WAIT_CELL) ? 3'd0 : cand_q + 3'd1;
    assign lim_c       = (mat_sel_c == WATER) ? 3'(NUM_CAND) : 3'(SAND_CAND);
    assign brush_cx_c  = (state_q == IDLE) ? draw_x_i : bcx_q;
    assign brush_cy_c  = (state_q == IDLE) ? draw_y_i : bcy_q;
    assign brush_mat_c = (state_q == IDLE) ? draw_material_i : bmat_q;

    neighbour_addr_gen #(
        .COLUMNS    (COLUMNS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .XW         (XW),
        .YW         (YW)
    ) u_nbr (
        .x_i            (x_q),
        .y_i            (y_q),
        .parity_i       (parity_q),
        .idx_i          (nxt_idx_c),
        .addr_c_o       (nbr_addr_c),
        .side_right_c_o (nbr_side_right_c),
        .valid_c_o      (cand_valid_c)
    );

    // First in-grid candidate at or after start_c for this material; no read for skipped slots
    always_comb begin
        found_c   = 1'b0;
        nxt_idx_c = 3'd0;
        for (int i = int'(NUM_CAND) - 1; i >= 0; i--) begin
            if (i >= int'(start_c) && i < int'(lim_c) && cand_valid_c[i]) begin
                found_c   = 1'b1;
                nxt_idx_c = 3'(i);
            end
        end
    end

    // Scan successor: step one column (two after a rightward water move), wrap to the row above
    always_comb begin
        xn     = int'(x_q) + (skip_q ? 2 : 1);
        last_c = 1'b0;
        if (xn >= int'(COLUMNS)) begin
            nx_c   = '0;
            ny_c   = y_q - YW'(1);
            last_c = (y_q == '0);
        end else begin
            nx_c   = XW'(xn);
            ny_c   = y_q;
        end
    end

    // Next-state and next-output logic; outputs are registered from the _d values
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        bcx_d        = bcx_q;
        bcy_d        = bcy_q;
        bx_d         = bx_q;
        by_d         = by_q;
        bmat_d       = bmat_q;
        cell_d       = cell_q;
        cand_d       = cand_q;
        tgt_addr_d   = tgt_addr_q;
        side_right_d = side_right_q;
        skip_d       = skip_q;
        parity_d     = parity_q;
        rd_addr_d    = rd_addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (tick_i && (state_q != IDLE));
        px           = 0;
        py           = 0;

        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    state_d   = RD_CELL;
                    x_d       = '0;
                    y_d       = YW'(ROWS - 1);
                    skip_d    = 1'b0;
                    rd_addr_d = cell_addr('0, YW'(ROWS - 1));
                end else if (draw_req_i) begin
                    state_d = BRUSH;
                    bx_d    = '0;
                    by_d    = '0;
                    bcx_d   = draw_x_i;
                    bcy_d   = draw_y_i;
                    bmat_d  = draw_material_i;
                end
            end
            BRUSH: begin
                if (bx_q == BW'(BSIDE - 1)) begin
                    bx_d = '0;
                    if (by_q == BW'(BSIDE - 1)) state_d = IDLE;
                    else                        by_d    = by_q + BW'(1);
                end else begin
                    bx_d = bx_q + BW'(1);
                end
            end
            RD_CELL: state_d = WAIT_CELL;
            WAIT_CELL: begin
                cell_d = rd_mat_c;
                if ((y_q != YW'(ROWS - 1)) && (rd_mat_c == SAND || rd_mat_c == WATER) && found_c) begin
                    state_d      = RD_NBR;
                    cand_d       = nxt_idx_c;
                    rd_addr_d    = nbr_addr_c;
                    tgt_addr_d   = nbr_addr_c;
                    side_right_d = nbr_side_right_c;
                end else begin
                    state_d = NEXT;
                end
            end
            RD_NBR: state_d = WAIT_NBR;
            WAIT_NBR: begin
                if (rd_data_i == '0) begin
                    state_d   = WR_DST;
                    wr_en_d   = 1'b1;
                    wr_addr_d = tgt_addr_q;
                    wr_data_d = CELL_WIDTH'(cell_q);
                    skip_d    = side_right_q && (cell_q == WATER);
                end else if (found_c) begin
                    state_d      = RD_NBR;
                    cand_d       = nxt_idx_c;
                    rd_addr_d    = nbr_addr_c;
                    tgt_addr_d   = nbr_addr_c;
                    side_right_d = nbr_side_right_c;
                end else begin
                    state_d = NEXT;
                end
            end
            WR_DST: begin
                state_d   = WR_SRC;
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(x_q, y_q);
                wr_data_d = '0;
            end
            WR_SRC: state_d = NEXT;
            NEXT: begin
                skip_d = 1'b0;
                if (last_c) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    parity_d     = ~parity_q;
                end else begin
                    state_d   = RD_CELL;
                    x_d       = nx_c;
                    y_d       = ny_c;
                    rd_addr_d = cell_addr(nx_c, ny_c);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == BRUSH) begin
            px = int'(brush_cx_c) + int'(bx_d) - int'(BRUSH_RADIUS);
            py = int'(brush_cy_c) + int'(by_d) - int'(BRUSH_RADIUS);
            if (px >= 0 && px < int'(COLUMNS) && py >= 0 && py < int'(ROWS)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_WIDTH'(py * int'(COLUMNS) + px);
                wr_data_d = brush_mat_c;
            end
        end

        busy_d      = (state_d != IDLE) && (state_d != BRUSH);
        draw_busy_d = (state_d == BRUSH);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            bcx_q        <= '0;
            bcy_q        <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            bmat_q       <= '0;
            cell_q       <= EMPTY;
            cand_q       <= '0;
            tgt_addr_q   <= '0;
            side_right_q <= 1'b0;
            skip_q       <= 1'b0;
            parity_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            draw_busy_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bcx_q        <= bcx_d;
            bcy_q        <= bcy_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            bmat_q       <= bmat_d;
            cell_q       <= cell_d;
            cand_q       <= cand_d;
            tgt_addr_q   <= tgt_addr_d;
            side_right_q <= side_right_d;
            skip_q       <= skip_d;
            parity_q     <= parity_d;
            rd_addr_q    <= rd_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            draw_busy_q  <= draw_busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_addr_o    = rd_addr_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;
    assign draw_busy_o  = draw_busy_q;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_multi_material_update_engine.sv
// Scoreboard bench on a 4x4 grid, brush radius 1, with a synchronous-read RAM model.
module tb_multi_material_update_engine;

    localparam int unsigned COLUMNS = 4;
    localparam int unsigned ROWS    = 4;
    localparam int unsigned CW      = 2;
    localparam int unsigned AW      = 4;
    localparam int unsigned R       = 1;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          tick = 1'b0;
    logic          draw_req = 1'b0;
    logic [1:0]    draw_x = '0;
    logic [1:0]    draw_y = '0;
    logic [CW-1:0] draw_mat = '0;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          busy, draw_busy, frame_done, overrun;

    logic [CW-1:0] mem [0:15];
    logic          cfg_we = 1'b0;
    logic          cfg_clr = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;

    int asserts = 0;
    int fails = 0;
    int exp_q[$];
    int mon_exp;
    int mon_got;
    int b_n, d_n, db_n, found;

    always #5 clk = ~clk;

    multi_material_update_engine #(
        .COLUMNS(COLUMNS), .ROWS(ROWS), .CELL_WIDTH(CW), .ADDR_WIDTH(AW), .BRUSH_RADIUS(R)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick), .draw_req_i(draw_req),
        .draw_x_i(draw_x), .draw_y_i(draw_y), .draw_material_i(draw_mat),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .draw_busy_o(draw_busy), .frame_done_o(frame_done), .overrun_o(overrun)
    );

    // Game-state RAM: one-cycle read latency, bench setup port takes precedence
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (cfg_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (cfg_we) begin
            mem[cfg_addr] <= cfg_data;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write monitor: every DUT write must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en) begin
            mon_got = int'(wr_addr) * 16 + int'(wr_data);
            asserts++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr=%0d data=%0d, none expected", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got != mon_exp) begin
                    fails++;
                    $display("FAIL write_match: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             wr_addr, wr_data, mon_exp / 16, mon_exp % 16);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic clear_mem();
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_clr = 1'b0;
    endtask

    task automatic poke(input int a, input int d);
        cfg_addr = AW'(a);
        cfg_data = CW'(d);
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic expect_wr(input int a, input int d);
        exp_q.push_back(a * 16 + d);
    endtask

    // One tick at cycle 0, optional second tick at tick2_at; counts busy cycles and done pulses
    task automatic run_frame(input int tick2_at, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < 300; c++) begin
            tick = (c == 0) || (c == tick2_at);
            @(negedge clk);
            if (busy) busy_n++;
            if (frame_done) done_n++;
        end
        tick = 1'b0;
    endtask

    task automatic run_brush(input int x, input int y, input int m, output int dbusy_n, output int busy_n);
        draw_x   = 2'(x);
        draw_y   = 2'(y);
        draw_mat = CW'(m);
        dbusy_n  = 0;
        busy_n   = 0;
        for (int c = 0; c < 30; c++) begin
            draw_req = (c == 0);
            @(negedge clk);
            if (draw_busy) dbusy_n++;
            if (busy) busy_n++;
        end
        draw_req = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_draw_busy", int'(draw_busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);

        // Sand at (1,0) falls to (1,1)
        clear_mem();
        poke(1, 1);
        expect_wr(5, 1); expect_wr(1, 0);
        run_frame(-1, b_n, d_n);
        check("fall_busy_cycles", b_n, 52);
        check("fall_done_pulses", d_n, 1);
        check("fall_queue_empty", exp_q.size(), 0);
        check("fall_dst", int'(mem[5]), 1);
        check("fall_src", int'(mem[1]), 0);

        // Sand over wall: even frame slides left, odd frame slides right
        do_reset();
        clear_mem();
        poke(9, 1); poke(13, 3);
        expect_wr(12, 1); expect_wr(9, 0);
        run_frame(-1, b_n, d_n);
        check("diag_even_busy", b_n, 54);
        check("diag_even_dst", int'(mem[12]), 1);
        check("diag_even_queue", exp_q.size(), 0);
        clear_mem();
        poke(9, 1); poke(13, 3);
        expect_wr(14, 1); expect_wr(9, 0);
        run_frame(-1, b_n, d_n);
        check("diag_odd_busy", b_n, 54);
        check("diag_odd_dst", int'(mem[14]), 1);
        check("diag_odd_left_untouched", int'(mem[12]), 0);
        check("diag_odd_queue", exp_q.size(), 0);

        // Water blocked below and diagonally spreads sideways left on an even frame
        do_reset();
        clear_mem();
        poke(12, 2); poke(9, 2); poke(13, 3); poke(14, 3);
        expect_wr(8, 2); expect_wr(9, 0);
        run_frame(-1, b_n, d_n);
        check("water_side_busy", b_n, 58);
        check("water_side_dst", int'(mem[8]), 2);
        check("water_side_queue", exp_q.size(), 0);

        // Sand at left edge: the off-grid left diagonal costs no read
        do_reset();
        clear_mem();
        poke(8, 1); poke(12, 3);
        expect_wr(13, 1); expect_wr(8, 0);
        run_frame(-1, b_n, d_n);
        check("edge_skip_busy", b_n, 54);
        check("edge_skip_dst", int'(mem[13]), 1);
        check("edge_skip_queue", exp_q.size(), 0);

        // Water moving sideways right is not reprocessed in the skipped column
        do_reset();
        clear_mem();
        poke(8, 2); poke(12, 3); poke(13, 3);
        expect_wr(9, 2); expect_wr(8, 0);
        run_frame(-1, b_n, d_n);
        check("skip_col_busy", b_n, 53);
        check("skip_col_dst", int'(mem[9]), 2);
        check("skip_col_no_double", int'(mem[14]), 0);
        check("skip_col_queue", exp_q.size(), 0);

        // Brush of WALL at the corner clips to four in-grid cells
        do_reset();
        clear_mem();
        expect_wr(0, 3); expect_wr(1, 3); expect_wr(4, 3); expect_wr(5, 3);
        run_brush(0, 0, 3, db_n, b_n);
        check("brush_draw_busy", db_n, 9);
        check("brush_not_busy", b_n, 0);
        check("brush_queue", exp_q.size(), 0);
        check("brush_cell11", int'(mem[5]), 3);
        check("brush_cell20", int'(mem[2]), 0);

        // Tick during an active frame is dropped and flags overrun
        do_reset();
        clear_mem();
        run_frame(10, b_n, d_n);
        check("overrun_done_pulses", d_n, 1);
        check("overrun_busy_cycles", b_n, 48);
        check("overrun_flag", int'(overrun), 1);
        do_reset();
        check("overrun_cleared", int'(overrun), 0);

        // Reset between destination and source writes aborts the move
        clear_mem();
        run_frame(-1, b_n, d_n);
        poke(1, 1);
        expect_wr(5, 1);
        found = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wr_en) begin
                found = 1;
                break;
            end
        end
        check("abort_saw_wr_dst", found, 1);
        reset_i = 1'b1;
        @(negedge clk);
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_queue", exp_q.size(), 0);
        check("abort_src_kept", int'(mem[1]), 1);
        clear_mem();
        poke(9, 1); poke(13, 3);
        expect_wr(12, 1); expect_wr(9, 0);
        run_frame(-1, b_n, d_n);
        check("abort_parity_even", int'(mem[12]), 1);
        check("abort_parity_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/multi_material_update_engine.md
MULTI_MATERIAL_UPDATE_ENGINE -- requirements
Module: multi_material_update_engine

Interface
REQ-001 SHALL have parameter COLUMNS, default 640, grid width in cells.
REQ-002 SHALL have parameter ROWS, default 480, grid height in cells.
REQ-003 SHALL have parameter CELL_WIDTH, default 2, material code bits, minimum 2.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(COLUMNS*ROWS), cell address width.
REQ-005 SHALL have parameter BRUSH_RADIUS, default 2, square brush half-size; brush side 2R+1.
REQ-006 SHALL have port clk_i  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-008 SHALL have port tick_i  input  1  one-cycle pulse requesting one simulation frame.
REQ-009 SHALL have port draw_req_i  input  1  brush request, level, sampled in IDLE.
REQ-010 SHALL have ports draw_x_i / draw_y_i  input  $clog2(COLUMNS) / $clog2(ROWS)  brush centre.
REQ-011 SHALL have port draw_material_i  input  CELL_WIDTH  material painted by brush.
REQ-012 SHALL have port rd_addr_o  output  ADDR_WIDTH  game-state RAM read address.
REQ-013 SHALL have port rd_data_i  input  CELL_WIDTH  RAM read data, valid one cycle after rd_addr_o.
REQ-014 SHALL have ports wr_en_o / wr_addr_o / wr_data_o  output  1 / ADDR_WIDTH / CELL_WIDTH  write to game-state RAM and VRAM simultaneously.
REQ-015 SHALL have ports busy_o, draw_busy_o, frame_done_o, overrun_o  output  1 each  frame active, brush active, end-of-frame pulse, sticky missed-tick flag.

Function
REQ-016 Material codes SHALL be EMPTY=0, SAND=1, WATER=2, WALL=3; codes above 3 SHALL be treated as WALL.
REQ-017 FSM states SHALL be IDLE, BRUSH, RD_CELL, WAIT_CELL, RD_NBR, WAIT_NBR, WR_DST, WR_SRC, NEXT.
REQ-018 In IDLE, tick_i SHALL start a frame (priority over draw_req_i if both high); else draw_req_i SHALL enter BRUSH.
REQ-019 tick_i arriving while not IDLE SHALL be dropped and SHALL set overrun_o until reset.
REQ-020 BRUSH SHALL write draw_material_i to every in-grid cell of the (2R+1)^2 square, row-major, one write per cycle; out-of-grid cells skipped with no write; draw_busy_o high throughout.
REQ-021 Frame scan SHALL go row ROWS-1 down to 0, columns 0 to COLUMNS-1; address = y*COLUMNS+x.
REQ-022 EMPTY/WALL cells and any cell in row ROWS-1 SHALL take no action beyond the read.
REQ-023 SAND SHALL try, in order: below, then below-first-diagonal, then below-second-diagonal; first EMPTY target wins.
REQ-024 Diagonal preference SHALL alternate per frame via frame parity bit: even frame left-first, odd frame right-first.
REQ-025 WATER SHALL try the SAND sequence, then same-row sides in the same parity order.
REQ-026 Candidates off the left/right edge SHALL be skipped without a RAM read.
REQ-027 A move SHALL be WR_DST (target <= material) then WR_SRC (source <= EMPTY), consecutive cycles.
REQ-028 After WATER moves right, the next column SHALL be skipped that frame (no double move).
REQ-029 Each candidate read SHALL cost 2 cycles (RD_NBR, WAIT_NBR); no speculative reads.
REQ-030 frame_done_o SHALL pulse one cycle when the last cell completes; parity SHALL toggle then; FSM SHALL return to IDLE.
REQ-031 wr_en_o SHALL be high only in BRUSH writes, WR_DST, WR_SRC; never two writes per cycle.
REQ-032 busy_o SHALL be high in every state except IDLE and BRUSH.

Reset
REQ-033 Reset SHALL force IDLE, parity 0, x=y=0, skip flag 0, and all outputs 0 (rd_addr_o, wr_* , busy_o, draw_busy_o, frame_done_o, overrun_o).
REQ-034 Reset mid-frame or mid-brush SHALL abort immediately; no further writes issued.

Structure
REQ-035 Material enum, state typedef, and CELL_WIDTH minimum SHALL live in shared package sand_pkg.
REQ-036 Neighbour candidate address and edge-validity generation SHALL be sub-module neighbour_addr_gen.

Verification (COLUMNS=4, ROWS=4, R=1)
REQ-037 SAND at (1,0), all else EMPTY, one tick -> writes (1,1)=1 then (1,0)=0; frame_done_o pulses once.
REQ-038 SAND at (1,2) over WALL at (1,3), even frame -> moves to (0,3); repeat setup odd frame -> (2,3).
REQ-039 WATER at (0,3) bottom row, WATER at (1,2) over WALL (1,3), (0,3),(2,3) full -> (1,2) moves sideways left on even frame; no edge read for x=-1.
REQ-040 draw_req_i at (0,0), material 3 -> exactly 4 writes: (0,0),(1,0),(0,1),(1,1) = 3.
REQ-041 tick_i pulsed during busy frame -> overrun_o=1, frame count unchanged; reset -> overrun_o=0.
REQ-042 reset_i asserted between WR_DST and WR_SRC -> wr_en_o=0 next cycle, state IDLE, parity 0.
